// File: rtl/risc_fsm_controller.sv
// Decoder and multi-cycle sequencer for the 16-bit RISC datapath.
// Holds one instruction and walks it through read, ALU and write-back states.
module risc_fsm_controller #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s,
  input  logic          load,
  input  logic [15:0]   in,
  output logic          w,
  output logic          err,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic          vsel,
  output logic          loada,
  output logic          loadb,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic          loadc,
  output logic          loads,
  output logic [DW-1:0] datapath_in
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_MOVI   = 3'd2,
    S_GET_A  = 3'd3,
    S_GET_B  = 3'd4,
    S_ALU    = 3'd5,
    S_WR     = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        err_q, err_d;

  logic [2:0] opc;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  assign opc = ir_q[15:13];
  assign op  = ir_q[12:11];
  assign rn  = ir_q[10:8];
  assign rd  = ir_q[7:5];
  assign sh  = ir_q[4:3];
  assign rm  = ir_q[2:0];

  logic is_movi;
  logic is_movr;
  logic is_alu;
  logic is_mvn;
  logic is_cmp;
  logic is_two;

  assign is_movi = (opc == 3'b110) && (op == 2'b10);
  assign is_movr = (opc == 3'b110) && (op == 2'b00);
  assign is_alu  = (opc == 3'b101);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_two  = is_alu && (op != 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    err_d   = err_q;
    unique case (state_q)
      S_WAIT: begin
        if (load) ir_d = in;
        if (s) begin
          state_d = S_DECODE;
          err_d   = 1'b0;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_movi:          state_d = S_MOVI;
          is_two:           state_d = S_GET_A;
          is_movr, is_mvn:  state_d = S_GET_B;
          default: begin
            state_d = S_WAIT;
            err_d   = 1'b1;
          end
        endcase
      end
      S_MOVI:  state_d = S_WAIT;
      S_GET_A: state_d = S_GET_B;
      S_GET_B: state_d = S_ALU;
      S_ALU:   state_d = is_cmp ? S_WAIT : S_WR;
      S_WR:    state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  // Moore outputs: everything idles at 0 outside the state that owns it.
  always_comb begin
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    loadc    = 1'b0;
    loads    = 1'b0;
    unique case (state_q)
      S_WAIT:   w = 1'b1;
      S_DECODE: ;
      S_MOVI: begin
        writenum = rn;
        vsel     = 1'b1;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = sh;
        ALUop = is_movr ? 2'b00 : op;
        asel  = is_movr | is_mvn;
        loads = is_cmp;
        loadc = ~is_cmp;
      end
      S_WR: begin
        writenum = rd;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

  assign err         = err_q;
  assign datapath_in = {{(DW-8){ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_risc_fsm_controller.sv
// Directed bench for risc_fsm_controller: cycle tables per instruction
// plus a reset-abort sequence.
module tb_risc_fsm_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w, err;
  logic [2:0]  readnum, writenum;
  logic        write, vsel, loada, loadb, asel, bsel;
  logic [1:0]  shift, ALUop;
  logic        loadc, loads;
  logic [15:0] datapath_in;

  risc_fsm_controller #(.DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .load(load), .in(in),
    .w(w), .err(err), .readnum(readnum), .writenum(writenum),
    .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .loadc(loadc), .loads(loads), .datapath_in(datapath_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic        err;
    logic [2:0]  rn;
    logic [2:0]  wn;
    logic        wr, vs, la, lb, as, bs;
    logic [1:0]  sh, op;
    logic        lc, ls;
    logic [15:0] dp;
  } out_t;

  typedef struct {
    logic  s;
    logic  ld;
    logic [15:0] in;
    out_t  exp;
    string name;
  } vec_t;

  out_t act;
  assign act = '{w: w, err: err, rn: readnum, wn: writenum,
                 wr: write, vs: vsel, la: loada, lb: loadb,
                 as: asel, bs: bsel, sh: shift, op: ALUop,
                 lc: loadc, ls: loads, dp: datapath_in};

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  function automatic out_t wt(logic e, logic [15:0] dp);
    out_t o = '0;
    o.w = 1'b1; o.err = e; o.dp = dp;
    return o;
  endfunction

  function automatic out_t dc(logic [15:0] dp);
    out_t o = '0;
    o.dp = dp;
    return o;
  endfunction

  function automatic out_t mi(logic [2:0] wn, logic [15:0] dp);
    out_t o = '0;
    o.wn = wn; o.vs = 1'b1; o.wr = 1'b1; o.dp = dp;
    return o;
  endfunction

  function automatic out_t ga(logic [2:0] rn, logic [15:0] dp);
    out_t o = '0;
    o.rn = rn; o.la = 1'b1; o.dp = dp;
    return o;
  endfunction

  function automatic out_t gb(logic [2:0] rn, logic [15:0] dp);
    out_t o = '0;
    o.rn = rn; o.lb = 1'b1; o.dp = dp;
    return o;
  endfunction

  function automatic out_t al(logic as_, logic [1:0] sh, logic [1:0] op,
                              logic lc, logic ls, logic [15:0] dp);
    out_t o = '0;
    o.as = as_; o.sh = sh; o.op = op; o.lc = lc; o.ls = ls; o.dp = dp;
    return o;
  endfunction

  function automatic out_t wb(logic [2:0] wn, logic [15:0] dp);
    out_t o = '0;
    o.wn = wn; o.wr = 1'b1; o.dp = dp;
    return o;
  endfunction

  task automatic add(logic s_, logic ld_, logic [15:0] in_, out_t e, string n);
    vec_t v;
    v.s = s_; v.ld = ld_; v.in = in_; v.exp = e; v.name = n;
    tbl.push_back(v);
  endtask

  task automatic check(string n, out_t e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, act, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; s = 1'b0; load = 1'b0; in = '0;
    #12;
    check("reset", wt(1'b0, 16'h0000));
    rst_n = 1'b1;
    step;
    check("reset_idle", wt(1'b0, 16'h0000));

    // MOV R0,#7
    add(1, 1, 16'hD007, dc(16'h0007), "t1_dec");
    add(0, 0, 16'h0000, mi(3'd0, 16'h0007), "t1_movi");
    add(0, 0, 16'h0000, wt(0, 16'h0007), "t1_wait");
    // MOV R1,#-2; s/load while busy must be ignored
    add(1, 1, 16'hD1FE, dc(16'hFFFE), "t2_dec");
    add(1, 1, 16'h0000, mi(3'd1, 16'hFFFE), "t2_movi");
    add(0, 0, 16'h0000, wt(0, 16'hFFFE), "t2_wait");
    // ADD R2,R1,R0,LSL#1
    add(1, 1, 16'hA148, dc(16'h0048), "t3_dec");
    add(0, 0, 16'h0000, ga(3'd1, 16'h0048), "t3_geta");
    add(0, 0, 16'h0000, gb(3'd0, 16'h0048), "t3_getb");
    add(0, 0, 16'h0000, al(0, 2'b01, 2'b00, 1, 0, 16'h0048), "t3_alu");
    add(0, 0, 16'h0000, wb(3'd2, 16'h0048), "t3_wr");
    add(0, 0, 16'h0000, wt(0, 16'h0048), "t3_wait");
    // CMP R1,R0
    add(1, 1, 16'hA900, dc(16'h0000), "t4_dec");
    add(0, 0, 16'h0000, ga(3'd1, 16'h0000), "t4_geta");
    add(0, 0, 16'h0000, gb(3'd0, 16'h0000), "t4_getb");
    add(0, 0, 16'h0000, al(0, 2'b00, 2'b01, 0, 1, 16'h0000), "t4_alu");
    add(0, 0, 16'h0000, wt(0, 16'h0000), "t4_wait");
    // MVN R7,R3,LSL#1
    add(1, 1, 16'hB8EB, dc(16'hFFEB), "mvn_dec");
    add(0, 0, 16'h0000, gb(3'd3, 16'hFFEB), "mvn_getb");
    add(0, 0, 16'h0000, al(1, 2'b01, 2'b11, 1, 0, 16'hFFEB), "mvn_alu");
    add(0, 0, 16'h0000, wb(3'd7, 16'hFFEB), "mvn_wr");
    add(0, 0, 16'h0000, wt(0, 16'hFFEB), "mvn_wait");
    // MOV R1,R2,LSR#1
    add(1, 1, 16'hC032, dc(16'h0032), "movr_dec");
    add(0, 0, 16'h0000, gb(3'd2, 16'h0032), "movr_getb");
    add(0, 0, 16'h0000, al(1, 2'b10, 2'b00, 1, 0, 16'h0032), "movr_alu");
    add(0, 0, 16'h0000, wb(3'd1, 16'h0032), "movr_wr");
    add(0, 0, 16'h0000, wt(0, 16'h0032), "movr_wait");
    // AND R5,R2,R5,LSL#1
    add(1, 1, 16'hB2AD, dc(16'hFFAD), "and_dec");
    add(0, 0, 16'h0000, ga(3'd2, 16'hFFAD), "and_geta");
    add(0, 0, 16'h0000, gb(3'd5, 16'hFFAD), "and_getb");
    add(0, 0, 16'h0000, al(0, 2'b01, 2'b10, 1, 0, 16'hFFAD), "and_alu");
    add(0, 0, 16'h0000, wb(3'd5, 16'hFFAD), "and_wr");
    add(0, 0, 16'h0000, wt(0, 16'hFFAD), "and_wait");
    // illegal words set sticky err; next s clears it
    add(1, 1, 16'h0000, dc(16'h0000), "t5_dec");
    add(0, 0, 16'h0000, wt(1, 16'h0000), "t5_err");
    add(0, 0, 16'h0000, wt(1, 16'h0000), "t5_sticky");
    add(1, 1, 16'hD805, dc(16'h0005), "ill2_dec");
    add(0, 0, 16'h0000, wt(1, 16'h0005), "ill2_err");
    // load without s, then s alone runs the held IR
    add(0, 1, 16'hD109, wt(1, 16'h0009), "ldonly");
    add(1, 0, 16'h0000, dc(16'h0009), "t5_clr");
    add(0, 0, 16'h0000, mi(3'd1, 16'h0009), "held_movi");
    add(0, 0, 16'h0000, wt(0, 16'h0009), "held_wait");

    for (int i = 0; i < tbl.size(); i++) begin
      s = tbl[i].s; load = tbl[i].ld; in = tbl[i].in;
      step;
      check(tbl[i].name, tbl[i].exp);
    end

    // reset during GET_B of an ADD aborts it immediately
    s = 1'b1; load = 1'b1; in = 16'hA148;
    step;
    s = 1'b0; load = 1'b0; in = '0;
    step;
    step;
    check("t6_getb", gb(3'd0, 16'h0048));
    #2 rst_n = 1'b0;
    #1 check("t6_abort", wt(0, 16'h0000));
    @(negedge clk);
    check("t6_hold", wt(0, 16'h0000));
    rst_n = 1'b1;
    #1;
    s = 1'b1; load = 1'b0;
    step;
    s = 1'b0;
    check("t6_dec", dc(16'h0000));
    step;
    check("t6_err", wt(1, 16'h0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
